// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: in-order {pc, instr} buffer between fetch and decode.
// Outputs come only from stored state, so IF inputs never reach ID outputs
// combinationally.
module if_id_queue #(
  parameter int unsigned     DEPTH     = 2,
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [XLEN-1:0]            if_pc,
  input  logic [XLEN-1:0]            if_instr,
  output logic                       if_ready,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            id_pc,
  output logic [XLEN-1:0]            id_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  entry_t           head;

  // Handshake qualifiers; readiness depends only on stored occupancy.
  assign if_ready = (count != CNT_W'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && id_ready;

  // Head presentation: the entry at rd_ptr, or a NOP bubble when empty.
  always_comb begin
    head     = mem[rd_ptr];
    id_pc    = '0;
    id_instr = NOP_INSTR;
    if (id_valid) begin
      id_pc    = head.pc;
      id_instr = head.instr;
    end
  end

  // Control state: pointers and occupancy; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: if_pc, instr: if_instr};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomized scoreboard bench for if_id_queue against a queue-based model.
`timescale 1ns/1ps
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  logic        if_ready;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [$clog2(DEPTH+1)-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] model [$];
  bit          model_ok = 1'b0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare DUT outputs with the model mid-cycle, then advance the model.
  task automatic monitor();
    int          sz;
    logic [63:0] h;
    forever begin
      @(negedge clk);
      sz = model.size();
      if (model_ok) begin
        chk("count",    64'(count),    64'(sz));
        chk("id_valid", 64'(id_valid), 64'(sz != 0));
        chk("if_ready", 64'(if_ready), 64'(sz != DEPTH));
        if (sz != 0) begin
          h = model[0];
          chk("id_pc",    64'(id_pc),    64'(h[63:32]));
          chk("id_instr", 64'(id_instr), 64'(h[31:0]));
        end else begin
          chk("id_pc_empty",    64'(id_pc),    64'(0));
          chk("id_instr_empty", 64'(id_instr), 64'(NOP));
        end
      end
      if (rst || flush) begin
        model.delete();
        if (rst) model_ok = 1'b1;
      end else begin
        if (id_ready && sz != 0) void'(model.pop_front());
        if (if_valid && sz != DEPTH) model.push_back({if_pc, if_instr});
      end
    end
  endtask

  // One clock of stimulus; returns 1ns after the edge with new outputs settled.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl, input logic r);
    if_valid = v; if_pc = pc; if_instr = ins;
    id_ready = rdy; flush = fl; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      monitor();
    join_none

    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);

    // Idle after reset
    chk("rst_valid", 64'(id_valid), 64'(0));
    chk("rst_instr", 64'(id_instr), 64'(32'h00000013));
    chk("rst_pc",    64'(id_pc),    64'(0));
    chk("rst_ready", 64'(if_ready), 64'(1));
    chk("rst_count", 64'(count),    64'(0));

    // Single push then pop
    drive(1, 32'h0, 32'h00500093, 0, 0, 0);
    chk("one_valid", 64'(id_valid), 64'(1));
    chk("one_pc",    64'(id_pc),    64'(0));
    chk("one_instr", 64'(id_instr), 64'(32'h00500093));
    chk("one_count", 64'(count),    64'(1));
    drive(0, 0, 0, 1, 0, 0);
    chk("pop_count", 64'(count),    64'(0));
    chk("pop_instr", 64'(id_instr), 64'(NOP));

    // Fill past capacity
    drive(1, 32'h0, 32'hA0, 0, 0, 0);
    drive(1, 32'h4, 32'hA4, 0, 0, 0);
    drive(1, 32'h8, 32'hA8, 0, 0, 0);
    chk("full_count", 64'(count),    64'(2));
    chk("full_ready", 64'(if_ready), 64'(0));
    chk("full_pc",    64'(id_pc),    64'(0));

    // Pop while full: push refused, head becomes 0x4
    drive(1, 32'h8, 32'hA8, 1, 0, 0);
    chk("fullpop_count", 64'(count), 64'(1));
    chk("fullpop_pc",    64'(id_pc), 64'(32'h4));

    // Simultaneous push/pop across pointer wrap
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'(8 + 4*i), 32'(32'hB0 + i), 1, 0, 0);
      chk("pp_count", 64'(count), 64'(1));
      chk("pp_pc",    64'(id_pc), 64'(8 + 4*i));
    end

    // Flush with concurrent push
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 32'h10, 32'hC0, 0, 0, 0);
    drive(1, 32'h14, 32'hC4, 0, 0, 0);
    drive(1, 32'h18, 32'hC8, 0, 1, 0);
    chk("fl_count", 64'(count),    64'(0));
    chk("fl_valid", 64'(id_valid), 64'(0));
    chk("fl_ready", 64'(if_ready), 64'(1));
    drive(1, 32'h40, 32'hD0, 0, 0, 0);
    chk("fl_next_pc", 64'(id_pc), 64'(32'h40));

    // Reset with flush, push and pop together
    drive(1, 32'h44, 32'hD4, 0, 0, 0);
    chk("pre_rst_count", 64'(count), 64'(2));
    drive(1, 32'h48, 32'hD8, 1, 1, 1);
    chk("r_count", 64'(count),    64'(0));
    chk("r_valid", 64'(id_valid), 64'(0));
    chk("r_pc",    64'(id_pc),    64'(0));
    chk("r_instr", 64'(id_instr), 64'(NOP));
    chk("r_ready", 64'(if_ready), 64'(1));
    drive(1, 32'h80, 32'hE0, 0, 0, 0);
    chk("r_next_pc",    64'(id_pc),    64'(32'h80));
    chk("r_next_count", 64'(count),    64'(1));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            $urandom & 32'hFFFF_FFFC,
            $urandom,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 127) == 0));
    end

    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
